// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl (with leaf fulladd4)
// Desc     : Adds NIBBLES-wide operands through one 4-bit adder, one nibble per
//            clock, LSB first; valid/ready handshakes on both sides.
//            Define NIBBLE_SUB_EN to add the sub port and subtract path.
// Revision : 1.0 - initial release
// ============================================================================

module fulladd4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] add,
    output logic       co
);
    logic [4:0] w_total;

    assign w_total = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    assign add     = w_total[3:0];
    assign co      = w_total[4];
endmodule

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 ci,
`ifdef NIBBLE_SUB_EN
    input  logic                 sub,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 busy
);
    localparam int               W        = 4 * NIBBLES;
    localparam int               IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_sum;
    logic             r_carry;
    logic             r_co;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_raw;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_add;
    logic             w_co;
    logic             w_init_carry;
    logic             w_last;

    assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
    assign w_b_raw = r_b[{r_idx, 2'b00} +: 4];
    assign w_last  = (r_idx == LAST_IDX);

`ifdef NIBBLE_SUB_EN
    logic r_sub;

    // Two's-complement subtract: invert B and inject the +1 as initial carry.
    assign w_b_nib      = w_b_raw ^ {4{r_sub}};
    assign w_init_carry = sub | ci;
`else
    assign w_b_nib      = w_b_raw;
    assign w_init_carry = ci;
`endif

    fulladd4 u_fulladd4 (
        .a   (w_a_nib),
        .b   (w_b_nib),
        .ci  (r_carry),
        .add (w_add),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_init_carry;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_add;
                    r_carry                    <= w_co;
                    if (w_last) begin
                        r_co    <= w_co;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef NIBBLE_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sub <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_sub <= sub;
        end
    end
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum       = r_sum;
    assign co        = r_co;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_add_ctrl
// Desc     : Directed vectors with a result scoreboard and independent monitor.
// Revision : 1.0 - initial release
// ============================================================================

module tb_nibble_serial_add_ctrl;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         ci        = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         sub_drv   = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         co;
    logic         busy;
    logic [W-1:0] sum;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef NIBBLE_SUB_EN
        .sub       (sub_drv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on output handshake.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && out_valid && !prev_ov) begin
            if (sb.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
            else                check("latency", cyc - sb[0].acc, NIBBLES);
        end
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sum", {16'h0, sum}, {16'h0, e.sum});
                check("co", {31'h0, co}, {31'h0, e.co});
            end
        end
        prev_ov = out_valid;
    end

    // Call at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vci,
                         input logic vsub, input logic [W-1:0] es, input logic eco,
                         input logic keep_valid, output int acc);
        int k;
        a        = va;
        b        = vb;
        ci       = vci;
        sub_drv  = vsub;
        in_valid = 1'b1;
        k        = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            k++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            acc      = -1;
            @(posedge clk);
            #1;
            return;
        end
        acc = cyc + 1;
        sb.push_back('{es, eco, acc});
        @(posedge clk);
        #1;
        if (!keep_valid) in_valid = 1'b0;
        a       = 16'hDEAD;
        b       = 16'hBEEF;
        ci      = ~vci;
        sub_drv = ~vsub;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] va_t [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'hABCD};
    logic [W-1:0] vb_t [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h1111};
    logic         vc_t [5] = '{1'b0,     1'b0,     1'b1,     1'b0,     1'b1};
    logic [W-1:0] es_t [5] = '{16'h1235, 16'h0000, 16'h0001, 16'h0000, 16'hBCDF};
    logic         ec_t [5] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};

    initial begin : stim
        int acc1;
        int acc2;
        int k;

        repeat (2) @(negedge clk);
        check("rst_state", {27'h0, in_ready, out_valid, busy, co, |sum},
                           {27'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            issue(va_t[i], vb_t[i], vc_t[i], 1'b0, es_t[i], ec_t[i], 1'b0, acc1);
            drain();
        end

        // Backpressure: hold result while new data is offered
        out_ready = 1'b0;
        issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, acc1);
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
            k++;
            @(negedge clk);
        end
        check("bp_wait_valid", {31'h0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a        = 16'hAAAA;
        b        = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {13'h0, out_valid, in_ready, co, sum},
                             {13'h0, 1'b1, 1'b0, 1'b0, 16'h1001});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_idle_after", {30'h0, in_ready, busy}, {30'h0, 1'b1, 1'b0});
        @(negedge clk);
        check("bp_new_not_taken", {30'h0, busy, out_valid}, 32'd0);
        check("bp_sb_empty", sb.size(), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-RUN at idx=2
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, acc1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_partial", {31'h0, |sum}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst", {27'h0, in_ready, out_valid, busy, co, |sum},
                         {27'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, acc1);
        drain();

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        issue(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, acc1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, acc2);
        check("b2b_interval", acc2 - acc1, NIBBLES + 2);
        drain();

`ifdef NIBBLE_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, acc1);
        drain();
        issue(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, acc1);
        drain();
        issue(16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, acc1);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
